clamp_arbiter: RTL and testbench

Shares a single fixed-point clamp datapath (max-then-min against constant limits) between two requesters.
- Each requester has its own limit pair.
- A round-robin arbiter grants one request per cycle into a one-stage registered clamp.
- The result is returned on a single valid/ready output port, tagged with requester id and clip flags.
- Per-requester saturating clip counters support range diagnostics.

---
 rtl/clamp_arbiter.sv | 158 +++++++++++++++
 tb/tb_clamp_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/clamp_arbiter.sv
// Two-requester round-robin arbiter in front of one registered fixed-point clamp.
// Results carry requester id and clip flags; per-requester saturating clip counters.
module clamp_arbiter #(
    parameter real MIN0    = -1.0,
    parameter real MAX0    = 1.0,
    parameter real MIN1    = -1.0,
    parameter real MAX1    = 1.0,
    parameter int  IN0_W   = 16,
    parameter int  IN0_EXP = -8,
    parameter int  IN1_W   = 16,
    parameter int  IN1_EXP = -8,
    parameter int  OUT_W   = 16,
    parameter int  OUT_EXP = -8,
    parameter int  CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN0_W-1:0] in0,
    input  logic                    in0_valid,
    output logic                    in0_ready,
    input  logic signed [IN1_W-1:0] in1,
    input  logic                    in1_valid,
    output logic                    in1_ready,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_id,
    output logic                    out_clip_lo,
    output logic                    out_clip_hi,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        clip_cnt0,
    output logic [CNT_W-1:0]        clip_cnt1
);
    function automatic int rnd(input real r);
        return (r < 0.0) ? $rtoi(r - 0.5) : $rtoi(r + 0.5);
    endfunction

    // Limits are quantised to each requester's own input format so the compare is exact.
    localparam logic signed [IN0_W-1:0] MIN0_Q = IN0_W'(rnd(MIN0 * (2.0 ** (-IN0_EXP))));
    localparam logic signed [IN0_W-1:0] MAX0_Q = IN0_W'(rnd(MAX0 * (2.0 ** (-IN0_EXP))));
    localparam logic signed [IN1_W-1:0] MIN1_Q = IN1_W'(rnd(MIN1 * (2.0 ** (-IN1_EXP))));
    localparam logic signed [IN1_W-1:0] MAX1_Q = IN1_W'(rnd(MAX1 * (2.0 ** (-IN1_EXP))));

    localparam int SH0 = IN0_EXP - OUT_EXP;
    localparam int SH1 = IN1_EXP - OUT_EXP;
    localparam int LS0 = (SH0 > 0) ? SH0 : 0;
    localparam int RS0 = (SH0 < 0) ? -SH0 : 0;
    localparam int LS1 = (SH1 > 0) ? SH1 : 0;
    localparam int RS1 = (SH1 < 0) ? -SH1 : 0;

    function automatic logic signed [OUT_W-1:0] conv(input logic signed [63:0] v,
                                                     input int ls, input int rs);
        logic signed [63:0] t;
        t = (v <<< ls) >>> rs;
        return t[OUT_W-1:0];
    endfunction

    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_id_q, out_id_d;
    logic                    clip_lo_q, clip_lo_d;
    logic                    clip_hi_q, clip_hi_d;
    logic                    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic                    slot_free, grant0, grant1;
    logic                    lo0, hi0, lo1, hi1;
    logic signed [IN0_W-1:0] c0;
    logic signed [IN1_W-1:0] c1;
    logic signed [OUT_W-1:0] o0, o1;

    always_comb begin
        lo0 = in0 < MIN0_Q;
        hi0 = in0 > MAX0_Q;
        c0  = lo0 ? MIN0_Q : (hi0 ? MAX0_Q : in0);
        lo1 = in1 < MIN1_Q;
        hi1 = in1 > MAX1_Q;
        c1  = lo1 ? MIN1_Q : (hi1 ? MAX1_Q : in1);
        o0  = conv(64'(c0), LS0, RS0);
        o1  = conv(64'(c1), LS1, RS1);
    end

    always_comb begin
        slot_free = !out_valid_q || out_ready;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (!rst && slot_free) begin
            // Under contention the requester that did not win last time goes next.
            if (in0_valid && in1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = in0_valid;
                grant1 = in1_valid;
            end
        end
    end

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        clip_lo_d    = clip_lo_q;
        clip_hi_d    = clip_hi_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (grant0 || grant1) begin
            out_d        = grant1 ? o1 : o0;
            out_valid_d  = 1'b1;
            out_id_d     = grant1;
            clip_lo_d    = grant1 ? lo1 : lo0;
            clip_hi_d    = grant1 ? hi1 : hi0;
            last_grant_d = grant1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (grant0 && (lo0 || hi0) && cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
            if (grant1 && (lo1 || hi1) && cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            out_id_q     <= 1'b0;
            clip_lo_q    <= 1'b0;
            clip_hi_q    <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            clip_lo_q    <= clip_lo_d;
            clip_hi_q    <= clip_hi_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign in0_ready   = grant0;
    assign in1_ready   = grant1;
    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign out_id      = out_id_q;
    assign out_clip_lo = clip_lo_q;
    assign out_clip_hi = clip_hi_q;
    assign clip_cnt0   = cnt0_q;
    assign clip_cnt1   = cnt1_q;
endmodule

// File: tb/tb_clamp_arbiter.sv
// Randomized + directed bench for clamp_arbiter against a real-valued reference model.
module tb_clamp_arbiter;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic signed [15:0] in0;
    logic signed [11:0] in1;
    logic in0_valid, in0_ready, in1_valid, in1_ready;
    logic signed [15:0] out;
    logic out_valid, out_ready, out_id, out_clip_lo, out_clip_hi, cnt_clr;
    logic [CNT_W-1:0] clip_cnt0, clip_cnt1;

    clamp_arbiter #(
        .MIN0(-2.5), .MAX0(2.5), .MIN1(-2.5), .MAX1(2.5),
        .IN0_W(16), .IN0_EXP(-8), .IN1_W(12), .IN1_EXP(-6),
        .OUT_W(16), .OUT_EXP(-8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in0(in0), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1(in1), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_clip_lo(out_clip_lo), .out_clip_hi(out_clip_hi),
        .cnt_clr(cnt_clr), .clip_cnt0(clip_cnt0), .clip_cnt1(clip_cnt1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: real-valued result, round-robin memory, counters.
    bit  m_valid = 0, m_id = 0, m_lo = 0, m_hi = 0, m_last = 1;
    real m_out = 0.0;
    int  m_cnt[2] = '{0, 0};

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check readies mid-cycle, clock, update model, check outputs.
    task automatic step(input bit v0, input int x0, input bit v1, input int x1,
                        input bit ordy, input bit clr, input bit r);
        int  win;
        real x, y;
        bit  lo, hi;
        in0_valid = v0; in0 = 16'(x0);
        in1_valid = v1; in1 = 12'(x1);
        out_ready = ordy; cnt_clr = clr; rst = r;
        #4;
        win = -1;
        if (!r && (!m_valid || ordy)) begin
            if (v0 && v1) win = m_last ? 0 : 1;
            else if (v0)  win = 0;
            else if (v1)  win = 1;
        end
        chk("in0_ready", in0_ready, win == 0);
        chk("in1_ready", in1_ready, win == 1);
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 0; m_out = 0.0; m_id = 0; m_lo = 0; m_hi = 0; m_last = 1;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            if (win >= 0) begin
                x  = (win == 1) ? x1 / 64.0 : x0 / 256.0;
                lo = x < -2.5;
                hi = x > 2.5;
                y  = lo ? -2.5 : (hi ? 2.5 : x);
                m_out = y; m_valid = 1; m_id = win[0]; m_lo = lo; m_hi = hi; m_last = win[0];
                if (!clr && (lo || hi) && m_cnt[win] < CMAX) m_cnt[win]++;
            end else if (ordy) begin
                m_valid = 0;
            end
            if (clr) begin m_cnt[0] = 0; m_cnt[1] = 0; end
        end
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out", out, $rtoi(m_out * 256.0));
            chk("out_id", out_id, m_id);
            chk("clip_lo", out_clip_lo, m_lo);
            chk("clip_hi", out_clip_hi, m_hi);
        end
        chk("clip_cnt0", clip_cnt0, m_cnt[0]);
        chk("clip_cnt1", clip_cnt1, m_cnt[1]);
    endtask

    function automatic int pick0();
        int k = $urandom_range(0, 9);
        if (k == 0) return 640;
        if (k == 1) return -640;
        return int'($urandom_range(0, 2560)) - 1280;
    endfunction

    function automatic int pick1();
        int k = $urandom_range(0, 9);
        if (k == 0) return 160;
        if (k == 1) return -160;
        return int'($urandom_range(0, 640)) - 320;
    endfunction

    initial begin
        rst = 1; in0 = 0; in1 = 0; in0_valid = 0; in1_valid = 0; out_ready = 0; cnt_clr = 0;
        @(posedge clk);
        #1;
        // Reset with requests pending: no grants, everything cleared.
        step(1, 256, 1, 64, 1, 0, 1);
        step(1, 256, 1, 64, 1, 0, 1);
        chk("rst_out", out, 0);
        chk("rst_id", out_id, 0);
        chk("rst_lo", out_clip_lo, 0);
        chk("rst_hi", out_clip_hi, 0);

        // Single requester, +3.0 clips to +2.5.
        step(1, 768, 0, 0, 1, 0, 0);
        chk("single_out", out, 640);
        chk("single_hi", out_clip_hi, 1);
        chk("single_cnt", clip_cnt0, 1);

        // Sweep -4.0..+4.0 on requester 0.
        for (int v = -4; v <= 4; v++) step(1, v * 256, 0, 0, 1, 0, 0);
        // Exact upper limit on requester 1 passes unflagged.
        step(0, 0, 1, 160, 1, 0, 0);
        chk("bound_out", out, 640);
        chk("bound_hi", out_clip_hi, 0);

        // Contention: alternate starting from whichever the round-robin owes.
        for (int i = 0; i < 6; i++) step(1, -1024, 1, 32, 1, 0, 0);

        // Backpressure: hold for 5 cycles then release.
        step(1, 300, 1, -50, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 300, 1, -50, 0, 0, 0);
        step(1, 300, 1, -50, 1, 0, 0);

        // Counter saturation, then clear on a clipped accept.
        for (int i = 0; i < 20; i++) step(1, 768, 0, 0, 1, 0, 0);
        chk("sat_cnt0", clip_cnt0, CMAX);
        step(1, 768, 0, 0, 1, 1, 0);
        chk("clr_cnt0", clip_cnt0, 0);

        // Reset mid-stream with a held output.
        step(1, 100, 1, 100, 0, 0, 0);
        step(1, 100, 1, 100, 0, 0, 1);
        step(1, 100, 1, 100, 1, 0, 0);
        chk("post_rst_id", out_id, 0);

        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, pick0(), $urandom_range(0, 3) != 0, pick1(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
